// File: rtl/seg7_bcd_display.sv
// Display output stage: converts a CPU-written binary value to six BCD digits with a
// sequential double-dabble engine and drives active-low seven-segment outputs.
module seg7_bcd_display #(
  parameter int DATA_W        = 20,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic              overflow,
  output logic [6:0]        hex0,
  output logic [6:0]        hex1,
  output logic [6:0]        hex2,
  output logic [6:0]        hex3,
  output logic [6:0]        hex4,
  output logic [6:0]        hex5,
  output logic [1:0]        state_dbg
);

  // Handshake: wr_en is a single-cycle strobe with no back-pressure; writes made while
  // busy land in a one-entry pending slot (latest wins), done pulses for one cycle.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int EXT_W = (DATA_W > 32) ? DATA_W : 32;
  localparam logic [EXT_W-1:0] MAX_DEC = EXT_W'(999999);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;
  localparam logic [6:0] RST_HIGH  = BLANK_LEADING ? SEG_BLANK : SEG_ZERO;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  endfunction

  state_t            state, state_next;
  logic [DATA_W-1:0] bin;
  logic [23:0]       bcd;
  logic [23:0]       bcd_adj;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;
  logic              pend_valid;
  logic [DATA_W-1:0] pend_data;
  logic              load;
  logic [DATA_W-1:0] load_data;
  logic              do_shift;
  logic              do_update;
  logic [6:0]        hex_q    [6];
  logic [6:0]        hex_next [6];
  logic              lead;

  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_data  = wr_data;
    do_shift   = 1'b0;
    do_update  = 1'b0;
    case (state)
      IDLE: begin
        if (wr_en) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        do_shift = 1'b1;
        if (cnt == CNT_W'(1)) state_next = UPDATE;
      end
      UPDATE: begin
        do_update = 1'b1;
        // A write arriving this very cycle is newer than anything pending.
        if (wr_en) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else if (pend_valid) begin
          load       = 1'b1;
          load_data  = pend_data;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
  end

  // Leading-zero blanking walks from the top digit down; hex0 always shows a digit.
  always_comb begin
    lead = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      lead = lead && (bcd[4*i +: 4] == 4'd0);
      if (ovf)                             hex_next[i] = SEG_DASH;
      else if (BLANK_LEADING && lead && i > 0) hex_next[i] = SEG_BLANK;
      else                                 hex_next[i] = seg(bcd[4*i +: 4]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bin        <= '0;
      bcd        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      valid      <= 1'b0;
      overflow   <= 1'b0;
      hex_q[0]   <= SEG_ZERO;
      for (int i = 1; i < 6; i++) hex_q[i] <= RST_HIGH;
    end else begin
      busy <= (state_next != IDLE);
      done <= do_update;
      if (do_update) begin
        valid    <= 1'b1;
        overflow <= ovf;
        for (int i = 0; i < 6; i++) hex_q[i] <= hex_next[i];
      end
      if (load) begin
        bin        <= load_data;
        bcd        <= '0;
        cnt        <= CNT_W'(DATA_W);
        ovf        <= (EXT_W'(load_data) > MAX_DEC);
        pend_valid <= 1'b0;
      end else if (do_shift) begin
        bcd <= {bcd_adj[22:0], bin[DATA_W-1]};
        bin <= {bin[DATA_W-2:0], 1'b0};
        cnt <= cnt - CNT_W'(1);
        if (wr_en) begin
          pend_valid <= 1'b1;
          pend_data  <= wr_data;
        end
      end
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];

endmodule

// File: tb/tb_seg7_bcd_display.sv
// Bench for seg7_bcd_display: arithmetic reference model checked every cycle, plus
// hand-computed display values for the directed scenarios.
module tb_seg7_bcd_display;

  localparam int DATA_W = 20;
  localparam int LAT    = DATA_W + 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              busy, done, valid, overflow;
  logic [6:0]        hex0, hex1, hex2, hex3, hex4, hex5;
  logic [1:0]        state_dbg;

  seg7_bcd_display #(.DATA_W(DATA_W), .BLANK_LEADING(1'b1)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .busy(busy), .done(done), .valid(valid), .overflow(overflow),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model: a value waits a fixed number of cycles and is then displayed.
  logic        m_busy, m_done, m_valid, m_ovf, m_pend_v;
  logic [6:0]  m_hex [6];
  int unsigned m_cur, m_pend;
  int          m_left;

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_valid = 0; m_ovf = 0; m_pend_v = 0; m_left = 0;
    m_hex[0] = 7'h40;
    for (int i = 1; i < 6; i++) m_hex[i] = 7'h7F;
  endtask

  task automatic model_show(input int unsigned v);
    int unsigned p;
    if (v > 999999) begin
      for (int i = 0; i < 6; i++) m_hex[i] = 7'h3F;
      m_ovf = 1;
    end else begin
      p = 1;
      for (int i = 0; i < 6; i++) begin
        m_hex[i] = (i > 0 && v < p) ? 7'h7F : seg_tab[(v / p) % 10];
        p = p * 10;
      end
      m_ovf = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock);
      if (reset) begin
        model_reset();
      end else begin
        m_done = 0;
        if (!m_busy) begin
          if (wr_en) begin
            m_cur = wr_data; m_left = LAT; m_busy = 1;
          end
        end else begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            model_show(m_cur);
            m_done = 1; m_valid = 1;
            if (wr_en) begin
              m_cur = wr_data; m_left = LAT; m_pend_v = 0;
            end else if (m_pend_v) begin
              m_cur = m_pend; m_left = LAT; m_pend_v = 0;
            end else begin
              m_busy = 0;
            end
          end else if (wr_en) begin
            m_pend = wr_data; m_pend_v = 1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("valid", 32'(valid), 32'(m_valid));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("hex0", 32'(hex0), 32'(m_hex[0]));
        check("hex1", 32'(hex1), 32'(m_hex[1]));
        check("hex2", 32'(hex2), 32'(m_hex[2]));
        check("hex3", 32'(hex3), 32'(m_hex[3]));
        check("hex4", 32'(hex4), 32'(m_hex[4]));
        check("hex5", 32'(hex5), 32'(m_hex[5]));
      end
    end
  end

  task automatic write(input int unsigned v);
    @(negedge clock);
    wr_en   = 1'b1;
    wr_data = DATA_W'(v);
    @(negedge clock);
    wr_en   = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!done && n < 100);
  endtask

  int n, dones;

  initial begin
    // Reset held two cycles with a write strobe that must be ignored.
    wr_en = 1'b1; wr_data = DATA_W'(777);
    repeat (2) @(negedge clock);
    reset = 1'b0; wr_en = 1'b0;
    chk_en = 1'b1;
    check("rst_hex0", 32'(hex0), 32'h40);
    check("rst_hex5", 32'(hex5), 32'h7F);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    repeat (5) @(negedge clock);

    write(123456);
    check("busy_at_T", 32'(busy), 32'h1);
    wait_done(n);
    check("latency", 32'(n), 32'(LAT));
    check("d123456_hex5", 32'(hex5), 32'h79);
    check("d123456_hex4", 32'(hex4), 32'h24);
    check("d123456_hex3", 32'(hex3), 32'h30);
    check("d123456_hex2", 32'(hex2), 32'h19);
    check("d123456_hex1", 32'(hex1), 32'h12);
    check("d123456_hex0", 32'(hex0), 32'h02);
    check("valid_set", 32'(valid), 32'h1);
    @(negedge clock);
    check("done_one_cycle", 32'(done), 32'h0);

    write(7);
    wait_done(n);
    check("d7_hex0", 32'(hex0), 32'h78);
    check("d7_hex1", 32'(hex1), 32'h7F);
    write(0);
    wait_done(n);
    check("d0_hex0", 32'(hex0), 32'h40);
    check("d0_hex1", 32'(hex1), 32'h7F);

    write(1000000);
    wait_done(n);
    check("ovf_hex3", 32'(hex3), 32'h3F);
    check("ovf_flag", 32'(overflow), 32'h1);
    write(999999);
    wait_done(n);
    check("max_hex5", 32'(hex5), 32'h10);
    check("max_hex0", 32'(hex0), 32'h10);
    check("max_ovf", 32'(overflow), 32'h0);

    // Writes during a conversion: only the latest one is shown next.
    write(5);
    repeat (3) @(negedge clock);
    write(9);
    repeat (2) @(negedge clock);
    write(42);
    wait_done(n);
    check("d5_hex0", 32'(hex0), 32'h12);
    check("d5_hex1", 32'(hex1), 32'h7F);
    wait_done(n);
    check("pend_latency", 32'(n), 32'(LAT));
    check("d42_hex0", 32'(hex0), 32'h24);
    check("d42_hex1", 32'(hex1), 32'h19);
    check("d42_hex2", 32'(hex2), 32'h7F);
    repeat (3) @(negedge clock);
    check("idle_busy", 32'(busy), 32'h0);

    // Reset in the middle of a conversion.
    write(123456);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_hex0", 32'(hex0), 32'h40);
    check("midrst_hex1", 32'(hex1), 32'h7F);
    check("midrst_valid", 32'(valid), 32'h0);
    dones = 0;
    repeat (30) begin
      @(negedge clock);
      if (done) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'h0);
    check("midrst_hex2", 32'(hex2), 32'h7F);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
